pwm_multi_ctrl_int: RTL and testbench
=====================================

# pwm_multi_ctrl_int

Multi-channel PWM generator with interrupt. It shares one period counter across `NUM_CH` channels. New period and duty values are double-buffered and applied only at a period boundary, so no output ever sees a glitched cycle. Out-of-range programming is clamped and flagged through a sticky per-channel status vector and a level interrupt to the PS. It sits between the AXI register block and the board PWM pins.

## Interface
- `NUM_CH`, 4: number of PWM channels (1..16).
- `CNT_W`, 20: counter/period/duty width in bits.
- `DEFAULT_PERIOD`, 1000000: active period after reset; must be ≥ 2 and < 2^CNT_W.
- `Clk`  in  1  sole clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `Enable`  in  1  run; low holds the counter at 0 and forces outputs low.
- `Period`  in  CNT_W  requested period in `Clk` cycles.
- `DutyCycle`  in  NUM_CH*CNT_W  requested high-time per channel; channel k is in bits [k*CNT_W +: CNT_W].
- `Load`  in  1  one-cycle strobe that captures `Period`/`DutyCycle` into staging.
- `IntClear`  in  NUM_CH+1  write-1-to-clear mask for `IntStatus`.
- `PWM_out`  out  NUM_CH  registered PWM outputs.
- `Interrupt`  out  1  registered OR of `IntStatus`.
- `IntStatus`  out  NUM_CH+1  sticky flags: bit k = channel k duty error; bit NUM_CH = period error.
- `PeriodTick`  out  1  one-cycle pulse on the cycle the counter wraps to 0.
- `Count`  out  CNT_W  current counter value.

## Operation
- Reset values:
  - `Count`=0, active period=`DEFAULT_PERIOD`, active duties=0, staging=0, pending=0.
  - `PWM_out`=0, `Interrupt`=0, `IntStatus`=0, `PeriodTick`=0.
- `Load` captures inputs into staging registers and sets `pending`. Validation is applied during capture:
  - `Period` < 2: staged period = 2, set `IntStatus[NUM_CH]`.
  - Channel duty > staged period: staged duty = staged period, set `IntStatus[k]`.
  - A second `Load` before the update overwrites staging; the last values win.
- Counter: counts 0..P-1, where P is the active period, then wraps to 0.
- Update: on the wrap edge with `pending`=1, active period and duties take the staged values and `pending` clears. The new period starts at `Count`=0.
- `Enable`=0: `Count` held at 0, `PWM_out`=0, `PeriodTick`=0. A pending update is applied on the next edge. On the edge after `Enable` rises, `Count`=1.
- Channel output: `PWM_out[k]` <= `Enable` && (`Count` < duty_k).
  - duty 0 gives a constant low output.
  - duty = P gives a constant high output.
- `IntStatus` is sticky. `IntClear` clears the masked bits. If a set and a clear hit the same bit in the same cycle, the set wins.
- Comparisons are unsigned at CNT_W width with no truncation. The counter never exceeds P-1.

## Timing
- `Load` at edge t: staging/`pending`/`IntStatus` valid after t.
- `Interrupt` is asserted one cycle after the status bit sets, and deasserts one cycle after the last bit clears.
- `PWM_out` lags `Count` by one cycle.
- `PeriodTick` is high during the cycle `Count`=0 that follows a wrap; it is not asserted at enable start.
- Mid-operation `Reset` asserts asynchronously:
  - All state returns to reset values immediately.
  - The staged update is discarded.
- `Load` coincident with the wrap edge: the old staging is applied; the new values become pending for the next wrap.

## Structure
- Package `pwm_pkg`:
  - `CNT_W` default.
  - Status-bit index constant `PERIOD_ERR_BIT` function of NUM_CH.
  - Minimum-period constant `MIN_PERIOD`=2.
- Sub-module `pwm_channel`, instantiated `NUM_CH` times: staging duty, active duty, clamp/error flag, registered compare output.
- Top level holds: counter, period staging, pending flag, status/interrupt logic.

## Test plan
- `NUM_CH`=4, `CNT_W`=8. `Load` P=10, duties 0/3/10/12, `Enable`=1 → after first wrap:
  - Outputs high for 0/3/10/10 cycles of every 10.
  - `IntStatus`=5'b01000, `Interrupt`=1 two cycles after `Load`.
- Mid-period `Load` P=20, duty0=5 while P=10 → period/duty unchanged until `Count` wraps from 9; next period is 20 cycles with 5 high.
- `Load` P=0 → period runs as 2, `IntStatus[4]`=1. Simultaneous `IntClear`=5'b10000 and a new bad `Load` → bit stays 1.
- `IntClear`=5'b11111 with no new errors → `IntStatus`=0, `Interrupt`=0 one cycle later.
- `Enable` low mid-period → `Count`=0 and `PWM_out`=0 next edge. `Enable` high → `Count` 1,2,…; `PeriodTick` first at the wrap.
- `Reset` pulse mid-period with pending update → all outputs 0 immediately. After release, period = `DEFAULT_PERIOD` and staged values are lost.

Source files
------------

// File: rtl/pwm_multi_ctrl_int_pkg.sv
// Shared constants for the multi-channel PWM controller.
// Status-vector layout: one duty-error bit per channel, period error in the top bit.
package pwm_pkg;

   localparam int CNT_W_DEFAULT = 20;
   localparam int MIN_PERIOD    = 2;

   // Index of the period-error flag; it sits just above the per-channel flags.
   function automatic int period_err_bit(input int num_ch);
      return num_ch;
   endfunction

endpackage

// File: rtl/pwm_multi_ctrl_int_channel.sv
// One PWM channel: staged and active duty registers, clamp against the staged
// period, and a registered compare against the shared counter.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
)
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             enable,
   input  logic             load,
   input  logic             update,
   input  logic [CNT_W-1:0] duty_req,
   input  logic [CNT_W-1:0] staged_period,
   input  logic [CNT_W-1:0] count,
   output logic             duty_err,
   output logic             pwm
);

   logic [CNT_W-1:0] staged_duty;
   logic [CNT_W-1:0] active_duty;

   assign duty_err = load && (duty_req > staged_period);

   // The update uses the staging contents from before this edge, so a load
   // landing on the same edge is held back for the following wrap.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         staged_duty <= '0;
         active_duty <= '0;
         pwm         <= 1'b0;
      end else begin
         if (load) begin
            staged_duty <= duty_err ? staged_period : duty_req;
         end
         if (update) begin
            active_duty <= staged_duty;
         end
         pwm <= enable && (count < active_duty);
      end
   end

endmodule

// File: rtl/pwm_multi_ctrl_int.sv
// Multi-channel PWM with a shared period counter, double-buffered period/duty
// updates applied at the period boundary, and a sticky error status with interrupt.
module pwm_multi_ctrl_int
   import pwm_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = CNT_W_DEFAULT,
   parameter int DEFAULT_PERIOD = 1000000
)
(
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    Enable,
   input  logic [CNT_W-1:0]        Period,
   input  logic [NUM_CH*CNT_W-1:0] DutyCycle,
   input  logic                    Load,
   input  logic [NUM_CH:0]         IntClear,
   output logic [NUM_CH-1:0]       PWM_out,
   output logic                    Interrupt,
   output logic [NUM_CH:0]         IntStatus,
   output logic                    PeriodTick,
   output logic [CNT_W-1:0]        Count
);

   localparam int PERIOD_ERR_BIT = period_err_bit(NUM_CH);

   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  active_period;
   logic [CNT_W-1:0]  staged_period;
   logic [CNT_W-1:0]  staged_period_next;
   logic              pending;
   logic              period_err;
   logic              wrap;
   logic              update;
   logic [NUM_CH-1:0] duty_err;
   logic [NUM_CH:0]   status_set;
   logic [NUM_CH:0]   status_q;
   logic              interrupt_q;
   logic              tick_q;

   assign period_err         = Period < CNT_W'(MIN_PERIOD);
   assign staged_period_next = period_err ? CNT_W'(MIN_PERIOD) : Period;

   // While disabled the counter sits at 0, so a pending update lands on the next edge.
   assign wrap   = Enable && (count_q >= active_period - CNT_W'(1));
   assign update = pending && (wrap || !Enable);

   always_comb begin
      status_set                 = '0;
      status_set[NUM_CH-1:0]     = duty_err;
      status_set[PERIOD_ERR_BIT] = Load && period_err;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         count_q       <= '0;
         active_period <= CNT_W'(DEFAULT_PERIOD);
         staged_period <= '0;
         pending       <= 1'b0;
         tick_q        <= 1'b0;
      end else begin
         if (!Enable || wrap) begin
            count_q <= '0;
         end else begin
            count_q <= count_q + CNT_W'(1);
         end
         tick_q <= wrap;
         if (update) begin
            active_period <= staged_period;
         end
         if (Load) begin
            staged_period <= staged_period_next;
            pending       <= 1'b1;
         end else if (update) begin
            pending <= 1'b0;
         end
      end
   end

   // New errors take priority over a clear of the same bit.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         status_q    <= '0;
         interrupt_q <= 1'b0;
      end else begin
         status_q    <= (status_q & ~IntClear) | status_set;
         interrupt_q <= |status_q;
      end
   end

   genvar k;
   generate
      for (k = 0; k < NUM_CH; k++) begin : g_ch
         pwm_channel #(
            .CNT_W(CNT_W)
         ) u_channel (
            .Clk          (Clk),
            .Reset        (Reset),
            .enable       (Enable),
            .load         (Load),
            .update       (update),
            .duty_req     (DutyCycle[k*CNT_W +: CNT_W]),
            .staged_period(staged_period_next),
            .count        (count_q),
            .duty_err     (duty_err[k]),
            .pwm          (PWM_out[k])
         );
      end
   endgenerate

   assign Count      = count_q;
   assign IntStatus  = status_q;
   assign Interrupt  = interrupt_q;
   assign PeriodTick = tick_q;

endmodule

// File: tb/tb_pwm_multi_ctrl_int.sv
// Self-checking bench for pwm_multi_ctrl_int: directed scenarios plus random
// programming, every cycle compared against a behavioural reference model.
module tb_pwm_multi_ctrl_int;

   localparam int NUM_CH         = 4;
   localparam int CNT_W          = 8;
   localparam int DEFAULT_PERIOD = 50;

   logic                    Clk;
   logic                    Reset;
   logic                    Enable;
   logic [CNT_W-1:0]        Period;
   logic [NUM_CH*CNT_W-1:0] DutyCycle;
   logic                    Load;
   logic [NUM_CH:0]         IntClear;
   logic [NUM_CH-1:0]       PWM_out;
   logic                    Interrupt;
   logic [NUM_CH:0]         IntStatus;
   logic                    PeriodTick;
   logic [CNT_W-1:0]        Count;

   int assertCount;
   int failCount;

   // Reference model state, kept as plain integers.
   int mCount;
   int mPeriod;
   int mDuty[NUM_CH];
   int mStagePeriod;
   int mStageDuty[NUM_CH];
   bit mPending;
   int mStatus;
   bit mInt;
   bit mTick;
   int mPwm;

   int reqPeriod;
   int reqDuty[NUM_CH];
   int highCnt[NUM_CH];
   int maxCount;

   pwm_multi_ctrl_int #(
      .NUM_CH        (NUM_CH),
      .CNT_W         (CNT_W),
      .DEFAULT_PERIOD(DEFAULT_PERIOD)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Enable    (Enable),
      .Period    (Period),
      .DutyCycle (DutyCycle),
      .Load      (Load),
      .IntClear  (IntClear),
      .PWM_out   (PWM_out),
      .Interrupt (Interrupt),
      .IntStatus (IntStatus),
      .PeriodTick(PeriodTick),
      .Count     (Count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mCount       = 0;
      mPeriod      = DEFAULT_PERIOD;
      mStagePeriod = 0;
      mPending     = 0;
      mStatus      = 0;
      mInt         = 0;
      mTick        = 0;
      mPwm         = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         mDuty[k]      = 0;
         mStageDuty[k] = 0;
      end
   endtask

   // One clock edge of the specified behaviour, computed from pre-edge values.
   task automatic modelEdge();
      bit wrapped;
      bit apply;
      int setBits;
      int sp;
      wrapped = Enable && (mCount == mPeriod - 1);
      mPwm = 0;
      for (int k = 0; k < NUM_CH; k++)
         if (Enable && (mCount < mDuty[k])) mPwm |= (1 << k);
      mTick  = wrapped;
      mInt   = (mStatus != 0);
      apply  = mPending && (wrapped || !Enable);
      mCount = (Enable && !wrapped) ? mCount + 1 : 0;
      if (apply) begin
         mPeriod = mStagePeriod;
         mDuty   = mStageDuty;
      end
      setBits = 0;
      if (Load) begin
         sp = (reqPeriod < 2) ? 2 : reqPeriod;
         if (reqPeriod < 2) setBits |= (1 << NUM_CH);
         mStagePeriod = sp;
         for (int k = 0; k < NUM_CH; k++) begin
            if (reqDuty[k] > sp) begin
               mStageDuty[k] = sp;
               setBits |= (1 << k);
            end else begin
               mStageDuty[k] = reqDuty[k];
            end
         end
         mPending = 1;
      end else if (apply) begin
         mPending = 0;
      end
      mStatus = (mStatus & ~int'(IntClear)) | setBits;
   endtask

   task automatic compareAll();
      checkOutput("count", Count, mCount);
      checkOutput("pwm", PWM_out, mPwm);
      checkOutput("tick", PeriodTick, mTick);
      checkOutput("status", IntStatus, mStatus);
      checkOutput("irq", Interrupt, mInt);
   endtask

   task automatic setDuties(input int d0, input int d1, input int d2, input int d3);
      reqDuty[0] = d0;
      reqDuty[1] = d1;
      reqDuty[2] = d2;
      reqDuty[3] = d3;
   endtask

   task automatic applyStimulus(input bit en, input bit ld, input int per, input int clr);
      Enable    = en;
      Load      = ld;
      reqPeriod = per;
      Period    = CNT_W'(per);
      IntClear  = (NUM_CH+1)'(clr);
      for (int k = 0; k < NUM_CH; k++)
         DutyCycle[k*CNT_W +: CNT_W] = CNT_W'(reqDuty[k]);
   endtask

   task automatic stepCycle();
      @(posedge Clk);
      modelEdge();
      #1;
      compareAll();
      Load     = 1'b0;
      IntClear = '0;
   endtask

   task automatic runCycles(input int n);
      repeat (n) stepCycle();
   endtask

   task automatic measureWindow(input int n);
      for (int k = 0; k < NUM_CH; k++) highCnt[k] = 0;
      maxCount = 0;
      repeat (n) begin
         stepCycle();
         for (int k = 0; k < NUM_CH; k++) highCnt[k] += int'(PWM_out[k]);
         if (int'(Count) > maxCount) maxCount = int'(Count);
      end
   endtask

   initial begin
      bit curEn;
      bit ld;
      int per;
      int clr;

      assertCount = 0;
      failCount   = 0;
      Reset       = 1'b0;
      setDuties(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      modelReset();
      #2;
      compareAll();
      @(negedge Clk);
      Reset = 1'b1;

      // Program P=10 with one out-of-range duty while running the default period.
      applyStimulus(1, 0, 0, 0);
      runCycles(2);
      setDuties(0, 3, 10, 12);
      applyStimulus(1, 1, 10, 0);
      stepCycle();
      checkOutput("load_status", IntStatus, 5'b01000);
      checkOutput("irq_lag0", Interrupt, 0);
      applyStimulus(1, 0, 10, 0);
      stepCycle();
      checkOutput("irq_lag1", Interrupt, 1);
      runCycles(60);
      measureWindow(10);
      checkOutput("high_ch0", highCnt[0], 0);
      checkOutput("high_ch1", highCnt[1], 3);
      checkOutput("high_ch2", highCnt[2], 10);
      checkOutput("high_ch3", highCnt[3], 10);

      // Mid-period reprogram to P=20 with duty0=5.
      runCycles(4);
      setDuties(5, 3, 10, 10);
      applyStimulus(1, 1, 20, 0);
      stepCycle();
      runCycles(25);
      measureWindow(20);
      checkOutput("p20_high0", highCnt[0], 5);
      checkOutput("p20_max", maxCount, 19);

      // Period below minimum, then a clear racing a fresh period error.
      setDuties(0, 1, 2, 2);
      applyStimulus(1, 1, 0, 0);
      stepCycle();
      checkOutput("perr_set", IntStatus[NUM_CH], 1);
      runCycles(45);
      measureWindow(4);
      checkOutput("p2_max", maxCount, 1);
      checkOutput("p2_high2", highCnt[2], 4);
      applyStimulus(1, 1, 1, 5'b10000);
      stepCycle();
      checkOutput("set_wins", IntStatus[NUM_CH], 1);

      applyStimulus(1, 0, 2, 5'b11111);
      stepCycle();
      checkOutput("clr_all", IntStatus, 0);
      stepCycle();
      checkOutput("irq_off", Interrupt, 0);

      // Enable dropped mid-period, then restarted.
      setDuties(6, 6, 12, 3);
      applyStimulus(1, 1, 12, 0);
      stepCycle();
      runCycles(10);
      applyStimulus(0, 0, 12, 0);
      stepCycle();
      checkOutput("dis_count", Count, 0);
      checkOutput("dis_pwm", PWM_out, 0);
      runCycles(3);
      applyStimulus(1, 0, 12, 0);
      stepCycle();
      checkOutput("en_count1", Count, 1);
      stepCycle();
      checkOutput("en_count2", Count, 2);
      runCycles(15);

      // Random programming, clears and enable toggles.
      curEn = 1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) curEn = !curEn;
         ld  = ($urandom_range(0, 11) == 0);
         per = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(2, 40));
         clr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : 0;
         setDuties(int'($urandom_range(0, 45)), int'($urandom_range(0, 45)),
                   int'($urandom_range(0, 45)), int'($urandom_range(0, 45)));
         applyStimulus(curEn, ld, per, clr);
         stepCycle();
      end

      // Asynchronous reset mid-period with an update still pending.
      setDuties(4, 8, 2, 1);
      applyStimulus(1, 1, 30, 0);
      stepCycle();
      runCycles(3);
      #2;
      Reset = 1'b0;
      #1;
      modelReset();
      compareAll();
      @(negedge Clk);
      Reset = 1'b1;
      applyStimulus(1, 0, 30, 0);
      measureWindow(60);
      checkOutput("rst_max", maxCount, DEFAULT_PERIOD - 1);
      checkOutput("rst_pwm", highCnt[0], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
